// File: rtl/adam_aes_encipher_iterative.sv
// -----------------------------------------------------------------------------
// adam_aes_sbox_byte
//   Forward AES S-box for one byte, as a combinational table lookup.
//   Ports:
//     in_byte   in   8   byte to substitute
//     out_byte  out  8   S-box(in_byte)
//
// adam_aes_encipher_iterative
//   Iterative AES-128 encryption datapath, one round per clock. Consumes the
//   11 round keys produced by the key expander and its one-cycle ready pulse.
//   Plaintext in and ciphertext out over valid/ready handshakes.
//   Ports:
//     clk              in   1          clock
//     reset_n          in   1          asynchronous, active-low reset
//     round_keys       in   128 x 11   round keys [0:NR], stable while loaded
//     keys_ready       in   1          pulse: round_keys now valid
//     keys_invalidate  in   1          new key expansion starting (aborts work)
//     in_valid         in   1          plaintext valid
//     in_ready         out  1          plaintext accepted on in_valid && in_ready
//     block_in         in   128        plaintext, byte0 = [127:120], column-major
//     out_valid        out  1          ciphertext valid, held until out_ready
//     out_ready        in   1          downstream ready
//     block_out        out  128        ciphertext, same byte order
//     busy             out  1          high while in ROUND or FINAL
// -----------------------------------------------------------------------------

module adam_aes_sbox_byte (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry for byte value b sits at bits [(255-b)*8 +: 8]; the first line
    // holds values 0x00..0x0f.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // (255 - b) * 8 == {~b, 3'b000} for an 8-bit b
    assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule

module adam_aes_encipher_iterative #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] round_keys [0:NR],
    input  logic         keys_ready,
    input  logic         keys_invalidate,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] block_out,
    output logic         busy
);

    generate
        if (NR != 10) begin : g_bad_nr
            $error("adam_aes_encipher_iterative: only NR == 10 (AES-128) is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } fsm_state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

    fsm_state_t   fsm_state;
    logic         keys_loaded;
    logic [3:0]   round_ctr;
    logic [127:0] state_reg;

    logic [127:0] sb_vec;   // SubBytes(state_reg)
    logic [127:0] sr_vec;   // ShiftRows(SubBytes(state_reg))
    logic [127:0] mc_vec;   // MixColumns(ShiftRows(SubBytes(state_reg)))

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // keys_invalidate masks in_ready in the same cycle so a block can never be
    // accepted against keys that are being replaced.
    assign in_ready = (fsm_state == IDLE) && keys_loaded && !keys_invalidate;

    // Byte i lives at [127-8i -: 8], row = i % 4, column = i / 4.
    // ShiftRows: the byte at (row, col) comes from (row, (col + row) % 4).
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            adam_aes_sbox_byte u_sbox (
                .in_byte  (state_reg[127-8*gi -: 8]),
                .out_byte (sb_vec[127-8*gi -: 8])
            );
            assign sr_vec[127-8*gi -: 8] =
                sb_vec[127-8*((gi % 4) + 4*(((gi / 4) + (gi % 4)) % 4)) -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0;
            logic [7:0] a1;
            logic [7:0] a2;
            logic [7:0] a3;
            assign a0 = sr_vec[127-32*gi -: 8];
            assign a1 = sr_vec[119-32*gi -: 8];
            assign a2 = sr_vec[111-32*gi -: 8];
            assign a3 = sr_vec[103-32*gi -: 8];
            // Multiply by 3 is xtime(a) ^ a.
            assign mc_vec[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mc_vec[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mc_vec[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mc_vec[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_state   <= IDLE;
            keys_loaded <= 1'b0;
            round_ctr   <= 4'd0;
            state_reg   <= 128'd0;
            block_out   <= 128'd0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Invalidate wins over a simultaneous ready pulse.
            if (keys_invalidate) begin
                keys_loaded <= 1'b0;
            end else if (keys_ready) begin
                keys_loaded <= 1'b1;
            end

            case (fsm_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= block_in ^ round_keys[0];
                        round_ctr <= 4'd1;
                        busy      <= 1'b1;
                        fsm_state <= ROUND;
                    end
                end

                ROUND: begin
                    if (keys_invalidate) begin
                        round_ctr <= 4'd0;
                        busy      <= 1'b0;
                        fsm_state <= IDLE;
                    end else begin
                        state_reg <= mc_vec ^ round_keys[round_ctr];
                        round_ctr <= round_ctr + 4'd1;
                        if (round_ctr == LAST_ROUND) begin
                            fsm_state <= FINAL;
                        end
                    end
                end

                FINAL: begin
                    round_ctr <= 4'd0;
                    busy      <= 1'b0;
                    if (keys_invalidate) begin
                        fsm_state <= IDLE;
                    end else begin
                        // Last round skips MixColumns.
                        block_out <= sr_vec ^ round_keys[NR];
                        out_valid <= 1'b1;
                        fsm_state <= OUT;
                    end
                end

                OUT: begin
                    // An abort drops out_valid without a handshake; block_out
                    // keeps the stale ciphertext but is never qualified.
                    if (keys_invalidate || out_ready) begin
                        out_valid <= 1'b0;
                        round_ctr <= 4'd0;
                        fsm_state <= IDLE;
                    end
                end

                default: begin
                    fsm_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adam_aes_encipher_iterative.sv
module tb_adam_aes_encipher_iterative;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] round_keys [0:10];
    logic         keys_ready = 1'b0;
    logic         keys_invalidate = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] block_in = 128'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] block_out;
    logic         busy;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic [7:0] tb_sbox [0:255];

    adam_aes_encipher_iterative #(.NR(10)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .round_keys      (round_keys),
        .keys_ready      (keys_ready),
        .keys_invalidate (keys_invalidate),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .block_in        (block_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .block_out       (block_out),
        .busy            (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box from the field inverse (x^254) and the affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h01;
            if (x == 8'h00) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            tb_sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                         {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        logic [1407:0] flat;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]], tb_sbox[t[31:24]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) flat[1407-32*i -: 32] = w[i];
        return flat;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [1407:0] rk = expand_key(key);
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[1407-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = tb_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[1407-128*r-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_round_keys(input logic [127:0] key);
        logic [1407:0] flat = expand_key(key);
        for (int r = 0; r < 11; r++) round_keys[r] = flat[1407-128*r -: 128];
    endtask

    task automatic pulse_keys_ready();
        keys_ready = 1'b1;
        tick();
        keys_ready = 1'b0;
    endtask

    // Present pt, wait for acceptance, then wait for out_valid.
    // lat = clock edges from the accept edge until out_valid is seen.
    task automatic encrypt(input logic [127:0] pt, output logic [127:0] ct,
                           output int lat, output logic timed_out);
        int n = 0;
        timed_out = 1'b0;
        block_in = pt;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin tick(); n++; end
        if (!in_ready) timed_out = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        if (!out_valid) timed_out = 1'b1;
        ct = block_out;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(); tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (block_out !== 128'd0) $display("FAIL reset_block_out: got %h expected 0", block_out); else passed++;
        reset_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL post_reset_in_ready: got %b expected 0", in_ready); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_no_keys();
        set_round_keys(KEY_C1);
        block_in = PT_C1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (in_ready !== 1'b0) $display("FAIL nokeys_in_ready: got %b expected 0", in_ready); else passed++;
            checks++; if (busy !== 1'b0) $display("FAIL nokeys_busy: got %b expected 0", busy); else passed++;
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL nokeys_out_valid: got %b expected 0", out_valid); else passed++;
        pulse_keys_ready();
        checks++; if (in_ready !== 1'b1) $display("FAIL keys_ready_in_ready: got %b expected 1", in_ready); else passed++;
        $display("test_no_keys done");
    endtask

    task automatic test_fips_c1();
        logic [127:0] ct;
        int lat;
        logic to;
        out_ready = 1'b0;
        encrypt(PT_C1, ct, lat, to);
        checks++; if (to !== 1'b0) $display("FAIL c1_timeout: got %b expected 0", to); else passed++;
        checks++; if (lat !== 10) $display("FAIL c1_latency: got %0d expected 10", lat); else passed++;
        checks++; if (ct !== CT_C1) $display("FAIL c1_ciphertext: got %h expected %h", ct, CT_C1); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL c1_busy_in_out: got %b expected 0", busy); else passed++;
        $display("test_fips_c1 ct=%h lat=%0d", ct, lat);
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        block_in = PT_B;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b expected 1", out_valid); else passed++;
            checks++; if (block_out !== CT_C1) $display("FAIL bp_block_out: got %h expected %h", block_out, CT_C1); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else passed++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (block_out !== CT_C1) $display("FAIL bp_release_block_out: got %h expected %h", block_out, CT_C1); else passed++;
        $display("test_backpressure done");
    endtask

    task automatic test_fips_b();
        logic [127:0] ct;
        int lat;
        logic to;
        keys_invalidate = 1'b1;
        tick();
        keys_invalidate = 1'b0;
        checks++; if (in_ready !== 1'b0) $display("FAIL invalidate_in_ready: got %b expected 0", in_ready); else passed++;
        set_round_keys(KEY_B);
        pulse_keys_ready();
        checks++; if (in_ready !== 1'b1) $display("FAIL reload_in_ready: got %b expected 1", in_ready); else passed++;
        out_ready = 1'b1;
        encrypt(PT_B, ct, lat, to);
        checks++; if (to !== 1'b0) $display("FAIL b_timeout: got %b expected 0", to); else passed++;
        checks++; if (ct !== CT_B) $display("FAIL b_ciphertext: got %h expected %h", ct, CT_B); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL b_handshake_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL b_handshake_in_ready: got %b expected 1", in_ready); else passed++;
        $display("test_fips_b ct=%h", ct);
    endtask

    task automatic test_abort();
        logic [127:0] ct;
        logic [127:0] exp;
        int lat;
        logic to;
        out_ready = 1'b1;
        block_in = PT_C1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy); else passed++;
        keys_invalidate = 1'b1;
        tick();
        keys_invalidate = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy_after: got %b expected 0", busy); else passed++;
        checks++; if (block_out !== CT_B) $display("FAIL abort_block_out_kept: got %h expected %h", block_out, CT_B); else passed++;
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b expected 0", out_valid); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL abort_in_ready: got %b expected 0", in_ready); else passed++;
        end
        in_valid = 1'b0;
        pulse_keys_ready();
        checks++; if (in_ready !== 1'b1) $display("FAIL abort_reload_in_ready: got %b expected 1", in_ready); else passed++;
        exp = model_encrypt(KEY_B, PT_C1);
        encrypt(PT_C1, ct, lat, to);
        checks++; if (to !== 1'b0) $display("FAIL abort_next_timeout: got %b expected 0", to); else passed++;
        checks++; if (ct !== exp) $display("FAIL abort_next_ciphertext: got %h expected %h", ct, exp); else passed++;
        tick();
        $display("test_abort next ct=%h", ct);
    endtask

    task automatic test_reset_mid();
        block_in = PT_B;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else passed++;
        checks++; if (block_out !== 128'd0) $display("FAIL midreset_block_out: got %h expected 0", block_out); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL midreset_in_ready: got %b expected 0", in_ready); else passed++;
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL midreset_keys_cleared: got %b expected 0", in_ready); else passed++;
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt;
        logic [127:0] exp;
        int acc;
        int prev = 0;
        int n;
        set_round_keys(KEY_C1);
        pulse_keys_ready();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp = model_encrypt(KEY_C1, pt);
            block_in = pt;
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 40) begin tick(); n++; end
            checks++; if (in_ready !== 1'b1) $display("FAIL b2b_accept_wait: got %b expected 1", in_ready); else passed++;
            tick();
            acc = cyc;
            in_valid = 1'b0;
            if (k > 0) begin
                checks++; if (acc - prev !== 12) $display("FAIL b2b_spacing: got %0d expected 12", acc - prev); else passed++;
            end
            prev = acc;
            n = 0;
            // A keys_ready pulse mid-block must not disturb the result.
            while (!out_valid && n < 40) begin
                keys_ready = (k == 1 && n == 3);
                tick();
                keys_ready = 1'b0;
                n++;
            end
            checks++; if (out_valid !== 1'b1) $display("FAIL b2b_out_valid: got %b expected 1", out_valid); else passed++;
            checks++; if (block_out !== exp) $display("FAIL b2b_ciphertext: got %h expected %h", block_out, exp); else passed++;
            $display("b2b block %0d pt=%h ct=%h", k, pt, block_out);
        end
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_final_out_valid: got %b expected 0", out_valid); else passed++;
    endtask

    initial begin
        for (int r = 0; r < 11; r++) round_keys[r] = 128'd0;
        build_sbox();
        test_reset();
        test_no_keys();
        test_fips_c1();
        test_backpressure();
        test_fips_b();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
